// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU pipeline control blocks.
// The pipe_ctl_t bundle is ordered PC, IF/ID write, IF/ID flush, ID/EX bubble, EX/MEM, MEM/WB.
package cpu_ctrl_pkg;

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2
   } state_e;

   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic ifid_flush;
      logic idex_bubble;
      logic exmem_write;
      logic memwb_write;
   } pipe_ctl_t;

   localparam pipe_ctl_t CTL_BOOT     = 6'b00_1100;
   localparam pipe_ctl_t CTL_FREEZE   = 6'b00_0000;
   localparam pipe_ctl_t CTL_LOAD_USE = 6'b00_0111;
   localparam pipe_ctl_t CTL_BRANCH   = 6'b11_1011;
   localparam pipe_ctl_t CTL_RUN      = 6'b11_0011;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear wins over inc.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk_i) begin
      if (clr) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: boot flush, load-use bubble, branch flush,
// data-memory freeze with timeout, and saturating stall/flush counters.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   BOOT     | flushing pipeline for BOOT_CYCLES cycles after reset
//   RUN      | normal issue; resolves load-use and branch hazards
//   MEM_WAIT | whole pipeline frozen until the data memory acks
module hazard_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int BOOT_CYCLES = 4,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  idex_memread_i,
   input  logic [REG_ADDR_W-1:0] idex_rt_i,
   input  logic [REG_ADDR_W-1:0] ifid_rs_i,
   input  logic [REG_ADDR_W-1:0] ifid_rt_i,
   input  logic                  branch_taken_i,
   input  logic                  dmem_req_i,
   input  logic                  dmem_ack_i,
   output logic                  pc_write_o,
   output logic                  ifid_write_o,
   output logic                  ifid_flush_o,
   output logic                  idex_bubble_o,
   output logic                  exmem_write_o,
   output logic                  memwb_write_o,
   output logic [CNT_W-1:0]      stall_cnt_o,
   output logic [CNT_W-1:0]      flush_cnt_o,
   output logic                  mem_err_o
);

   localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   state_e              state, state_nxt;
   logic [BOOT_W-1:0]   boot_cnt;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                mem_err;
   logic                load_use;
   pipe_ctl_t           run_ctl;
   pipe_ctl_t           ctl;
   logic                stall_inc;
   logic                flush_inc;

   // Register 0 is hard-wired zero, so a load targeting it never creates a dependency.
   assign load_use = idex_memread_i && (idex_rt_i != REG_ZERO) &&
                     ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

   always_comb begin
      run_ctl = CTL_RUN;
      if (load_use) begin
         run_ctl = CTL_LOAD_USE;
      end else if (branch_taken_i) begin
         run_ctl = CTL_BRANCH;
      end
   end

   always_comb begin
      state_nxt = state;
      ctl       = CTL_BOOT;
      case (state)
         BOOT: begin
            ctl = CTL_BOOT;
            if (boot_cnt == BOOT_LAST) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (dmem_req_i && !dmem_ack_i) begin
               ctl       = CTL_FREEZE;
               state_nxt = MEM_WAIT;
            end else begin
               ctl = run_ctl;
            end
         end
         MEM_WAIT: begin
            if (dmem_ack_i) begin
               ctl       = run_ctl;
               state_nxt = RUN;
            end else begin
               ctl = CTL_FREEZE;
            end
         end
         default: begin
            ctl       = CTL_BOOT;
            state_nxt = BOOT;
         end
      endcase
      if (rst_i) begin
         ctl       = CTL_BOOT;
         state_nxt = BOOT;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= BOOT;
         boot_cnt <= '0;
         wait_cnt <= '0;
         mem_err  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == BOOT && boot_cnt != BOOT_LAST) begin
            boot_cnt <= boot_cnt + 1'b1;
         end
         if (state == MEM_WAIT && !dmem_ack_i) begin
            if (wait_cnt != WAIT_MAX) begin
               wait_cnt <= wait_cnt + 1'b1;
            end
            // Flag on the edge that completes the MEM_TIMEOUT-th wait cycle.
            if (wait_cnt >= WAIT_LAST) begin
               mem_err <= 1'b1;
            end
         end else begin
            wait_cnt <= '0;
         end
      end
   end

   assign stall_inc = !rst_i && (state != BOOT) && !ctl.pc_write;
   assign flush_inc = !rst_i && (state == RUN) && ctl.ifid_flush;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .clr   (rst_i),
      .inc   (stall_inc),
      .count (stall_cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i (clk_i),
      .clr   (rst_i),
      .inc   (flush_inc),
      .count (flush_cnt_o)
   );

   assign pc_write_o    = ctl.pc_write;
   assign ifid_write_o  = ctl.ifid_write;
   assign ifid_flush_o  = ctl.ifid_flush;
   assign idex_bubble_o = ctl.idex_bubble;
   assign exmem_write_o = ctl.exmem_write;
   assign memwb_write_o = ctl.memwb_write;
   assign mem_err_o     = mem_err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: boot, load-use, branch, memory wait, timeout and saturation.
module tb_hazard_ctrl;

   localparam logic [5:0] E_BOOT   = 6'b001100;
   localparam logic [5:0] E_FREEZE = 6'b000000;
   localparam logic [5:0] E_LU     = 6'b000111;
   localparam logic [5:0] E_BR     = 6'b111011;
   localparam logic [5:0] E_RUN    = 6'b110011;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       idex_memread_i;
   logic [4:0] idex_rt_i, ifid_rs_i, ifid_rt_i;
   logic       branch_taken_i, dmem_req_i, dmem_ack_i;

   logic        pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, exmem_write_o, memwb_write_o;
   logic [31:0] stall_cnt_o, flush_cnt_o;
   logic        mem_err_o;

   logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_exmem_write, s_memwb_write;
   logic [1:0]  s_stall_cnt, s_flush_cnt;
   logic        s_mem_err;

   logic [5:0]  ctl;
   int          checks = 0;
   int          errors = 0;

   assign ctl = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, exmem_write_o, memwb_write_o};

   always #5 clk_i = ~clk_i;

   hazard_ctrl #(.BOOT_CYCLES(4), .MEM_TIMEOUT(8), .CNT_W(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
      .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i),
      .branch_taken_i(branch_taken_i), .dmem_req_i(dmem_req_i), .dmem_ack_i(dmem_ack_i),
      .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
      .idex_bubble_o(idex_bubble_o), .exmem_write_o(exmem_write_o), .memwb_write_o(memwb_write_o),
      .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .mem_err_o(mem_err_o)
   );

   // Narrow-counter copy driven by the same stimulus, used to observe saturation.
   hazard_ctrl #(.BOOT_CYCLES(4), .MEM_TIMEOUT(8), .CNT_W(2)) dut_sat (
      .clk_i(clk_i), .rst_i(rst_i),
      .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
      .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i),
      .branch_taken_i(branch_taken_i), .dmem_req_i(dmem_req_i), .dmem_ack_i(dmem_ack_i),
      .pc_write_o(s_pc_write), .ifid_write_o(s_ifid_write), .ifid_flush_o(s_ifid_flush),
      .idex_bubble_o(s_idex_bubble), .exmem_write_o(s_exmem_write), .memwb_write_o(s_memwb_write),
      .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt), .mem_err_o(s_mem_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_i = 1'b1; idex_memread_i = 1'b0; idex_rt_i = '0; ifid_rs_i = '0; ifid_rt_i = '0;
      branch_taken_i = 1'b0; dmem_req_i = 1'b0; dmem_ack_i = 1'b0;
      tick(); tick();
      chk("rst_ctl", 32'(ctl), 32'(E_BOOT));
      chk("rst_stall", stall_cnt_o, 0);
      chk("rst_flush", flush_cnt_o, 0);
      chk("rst_err", 32'(mem_err_o), 0);

      rst_i = 1'b0; #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("boot_ctl_%0d", i), 32'(ctl), 32'(E_BOOT));
         tick();
      end
      chk("run_ctl", 32'(ctl), 32'(E_RUN));
      chk("boot_no_stall", stall_cnt_o, 0);
      chk("boot_no_flush", flush_cnt_o, 0);

      // load-use on rs
      idex_memread_i = 1'b1; idex_rt_i = 5'd5; ifid_rs_i = 5'd5; ifid_rt_i = 5'd1; #1;
      chk("lu_rs_ctl", 32'(ctl), 32'(E_LU));
      tick();
      idex_memread_i = 1'b0; #1;
      chk("lu_release", 32'(ctl), 32'(E_RUN));
      chk("lu_stall_cnt", stall_cnt_o, 1);

      // load to r0 never stalls; mismatched registers never stall
      idex_memread_i = 1'b1; idex_rt_i = 5'd0; ifid_rs_i = 5'd0; ifid_rt_i = 5'd0; #1;
      chk("lu_r0_ctl", 32'(ctl), 32'(E_RUN));
      idex_rt_i = 5'd9; ifid_rs_i = 5'd3; ifid_rt_i = 5'd4; #1;
      chk("lu_miss_ctl", 32'(ctl), 32'(E_RUN));

      // load-use on rt with simultaneous branch: branch waits one cycle
      idex_rt_i = 5'd7; ifid_rt_i = 5'd7; branch_taken_i = 1'b1; #1;
      chk("lu_br_ctl", 32'(ctl), 32'(E_LU));
      tick();
      idex_memread_i = 1'b0; #1;
      chk("br_ctl", 32'(ctl), 32'(E_BR));
      chk("lu_rt_stall_cnt", stall_cnt_o, 2);
      chk("br_flush_pre", flush_cnt_o, 0);
      tick();
      branch_taken_i = 1'b0; #1;
      chk("br_done_ctl", 32'(ctl), 32'(E_RUN));
      chk("br_flush_cnt", flush_cnt_o, 1);

      // memory request acked 3 cycles later: 3 stall cycles, release on ack
      dmem_req_i = 1'b1; #1;
      chk("mw_entry", 32'(ctl), 32'(E_FREEZE));
      tick(); #1;
      chk("mw_wait1", 32'(ctl), 32'(E_FREEZE));
      tick(); #1;
      chk("mw_wait2", 32'(ctl), 32'(E_FREEZE));
      tick();
      dmem_ack_i = 1'b1; #1;
      chk("mw_ack", 32'(ctl), 32'(E_RUN));
      tick();
      dmem_req_i = 1'b0; dmem_ack_i = 1'b0; #1;
      chk("mw_stall_cnt", stall_cnt_o, 5);
      chk("mw_run", 32'(ctl), 32'(E_RUN));

      // load-use during a wait is held off until the ack cycle
      dmem_req_i = 1'b1; #1;
      chk("mwl_entry", 32'(ctl), 32'(E_FREEZE));
      tick();
      idex_memread_i = 1'b1; idex_rt_i = 5'd5; ifid_rs_i = 5'd5; #1;
      chk("mwl_wait1", 32'(ctl), 32'(E_FREEZE));
      tick(); #1;
      chk("mwl_wait2", 32'(ctl), 32'(E_FREEZE));
      tick();
      dmem_ack_i = 1'b1; #1;
      chk("mwl_ack_lu", 32'(ctl), 32'(E_LU));
      tick();
      dmem_req_i = 1'b0; dmem_ack_i = 1'b0; idex_memread_i = 1'b0; #1;
      chk("mwl_stall_cnt", stall_cnt_o, 9);
      chk("mwl_run", 32'(ctl), 32'(E_RUN));

      // req and ack in the same RUN cycle: no stall
      dmem_req_i = 1'b1; dmem_ack_i = 1'b1; #1;
      chk("same_cycle_ctl", 32'(ctl), 32'(E_RUN));
      tick();
      dmem_req_i = 1'b0; dmem_ack_i = 1'b0; #1;
      chk("same_cycle_stall", stall_cnt_o, 9);
      chk("same_cycle_run", 32'(ctl), 32'(E_RUN));

      // timeout: ack withheld, error after the 8th wait cycle, sticky past the ack
      dmem_req_i = 1'b1; #1;
      tick();
      for (int k = 1; k <= 8; k++) begin
         chk($sformatf("to_pre_err_%0d", k), 32'(mem_err_o), 0);
         tick();
      end
      chk("to_err_set", 32'(mem_err_o), 1);
      for (int k = 9; k <= 19; k++) begin
         chk($sformatf("to_freeze_%0d", k), 32'(ctl), 32'(E_FREEZE));
         tick();
      end
      dmem_ack_i = 1'b1; #1;
      chk("to_ack_ctl", 32'(ctl), 32'(E_RUN));
      tick();
      dmem_req_i = 1'b0; dmem_ack_i = 1'b0; #1;
      chk("to_err_sticky", 32'(mem_err_o), 1);
      chk("to_stall_cnt", stall_cnt_o, 29);
      chk("sat_stall_cnt", 32'(s_stall_cnt), 3);
      chk("sat_flush_cnt", 32'(s_flush_cnt), 1);
      chk("sat_err", 32'(s_mem_err), 1);

      // reset clears error and counters; reset mid-BOOT restarts the full boot
      rst_i = 1'b1; #1;
      chk("rst2_ctl", 32'(ctl), 32'(E_BOOT));
      tick();
      rst_i = 1'b0; #1;
      chk("rst2_err", 32'(mem_err_o), 0);
      chk("rst2_stall", stall_cnt_o, 0);
      chk("rst2_flush", flush_cnt_o, 0);
      tick(); tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0; #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("reboot_ctl_%0d", i), 32'(ctl), 32'(E_BOOT));
         tick();
      end
      chk("reboot_run", 32'(ctl), 32'(E_RUN));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
